// File: rtl/lmmi_cfg_pkg.sv
// Shared types for the LMMI configuration sequencer: FSM states, LMMI direction
// encodings and the table entry layout.
package lmmi_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WREQ  = 3'd2,
    ST_RREQ  = 3'd3,
    ST_RWAIT = 3'd4,
    ST_NEXT  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  localparam logic LMMI_WRITE = 1'b1;
  localparam logic LMMI_READ  = 1'b0;

  localparam int ENT_OFS_W  = 8;
  localparam int ENT_DATA_W = 8;

  typedef struct packed {
    logic [ENT_OFS_W-1:0]  ofs;
    logic [ENT_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/lmmi_tmo_cnt.sv
// Saturating, clearable cycle counter; expired is high once the count sits at LIMIT-1.
module lmmi_tmo_cnt #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/lmmi_cfg_seq.sv
// Walks an offset/data table and issues one LMMI write per entry with a per-transaction timeout.
// Define LMMI_CFG_SEQ_VERIFY_EN to read back and compare every entry after its write.
module lmmi_cfg_seq
  import lmmi_cfg_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int OFS_W       = ENT_OFS_W,
  parameter int DATA_W      = ENT_DATA_W,
  parameter int TMO_CYC     = 64,
  localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [OFS_W-1:0]  tbl_ofs,
  input  logic [DATA_W-1:0] tbl_data,
  output logic              lmmi_request,
  output logic              lmmi_wr_rdn,
  output logic [OFS_W-1:0]  lmmi_offset,
  output logic [DATA_W-1:0] lmmi_wdata,
  input  logic              lmmi_ready,
  input  logic [DATA_W-1:0] lmmi_rdata,
  input  logic              lmmi_rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [IDX_W-1:0]  err_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, err_idx_q, err_idx_d;
  logic               req_q, req_d, wr_q, wr_d, err_q, err_d;
  logic [OFS_W-1:0]   ofs_q, ofs_d;
  logic [DATA_W-1:0]  wdat_q, wdat_d;
  logic               tmo_clr, tmo_en, tmo_exp;

  lmmi_tmo_cnt #(.LIMIT(TMO_CYC)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_exp)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_idx_d = err_idx_q;
    req_d     = req_q;
    wr_d      = wr_q;
    err_d     = err_q;
    ofs_d     = ofs_q;
    wdat_d    = wdat_q;
    tmo_clr   = 1'b0;
    tmo_en    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        idx_d     = '0;
        err_d     = 1'b0;
        err_idx_d = '0;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        ofs_d   = tbl_ofs;
        wdat_d  = tbl_data;
        wr_d    = LMMI_WRITE;
        req_d   = 1'b1;
        tmo_clr = 1'b1;
        state_d = ST_WREQ;
      end
      // ready is checked before expiry so a late-but-in-time accept still succeeds
      ST_WREQ: begin
        tmo_en = 1'b1;
        if (lmmi_ready) begin
`ifdef LMMI_CFG_SEQ_VERIFY_EN
          wr_d    = LMMI_READ;
          tmo_clr = 1'b1;
          state_d = ST_RREQ;
`else
          req_d   = 1'b0;
          state_d = ST_NEXT;
`endif
        end else if (tmo_exp) begin
          req_d   = 1'b0;
          state_d = ST_ERR;
        end
      end
`ifdef LMMI_CFG_SEQ_VERIFY_EN
      ST_RREQ: begin
        tmo_en = 1'b1;
        if (lmmi_ready) begin
          req_d   = 1'b0;
          tmo_clr = 1'b1;
          state_d = ST_RWAIT;
        end else if (tmo_exp) begin
          req_d   = 1'b0;
          state_d = ST_ERR;
        end
      end
      ST_RWAIT: begin
        tmo_en = 1'b1;
        if (lmmi_rdata_valid) begin
          state_d = (lmmi_rdata == tbl_data) ? ST_NEXT : ST_ERR;
        end else if (tmo_exp) begin
          state_d = ST_ERR;
        end
      end
`endif
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_ERR: begin
        err_d     = 1'b1;
        err_idx_d = idx_q;
        req_d     = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      err_idx_q <= '0;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      ofs_q     <= '0;
      wdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_idx_q <= err_idx_d;
      req_q     <= req_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      ofs_q     <= ofs_d;
      wdat_q    <= wdat_d;
    end
  end

`ifndef LMMI_CFG_SEQ_VERIFY_EN
  logic unused_rd;
  assign unused_rd = ^{lmmi_rdata, lmmi_rdata_valid, LMMI_READ};
`endif

  assign tbl_idx      = idx_q;
  assign lmmi_request = req_q;
  assign lmmi_wr_rdn  = wr_q;
  assign lmmi_offset  = ofs_q;
  assign lmmi_wdata   = wdat_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_NEXT) && (idx_q == LAST_IDX);
  assign error        = err_q;
  assign err_idx      = err_idx_q;

endmodule

// File: tb/tb_lmmi_cfg_seq.sv
// Bench for lmmi_cfg_seq: directed and randomized runs against a responding LMMI target model.
module tb_lmmi_cfg_seq;
  import lmmi_cfg_pkg::*;

  localparam int NE  = 4;
  localparam int TMO = 64;
  localparam int IW  = 2;
`ifdef LMMI_CFG_SEQ_VERIFY_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] tbl_idx;
  logic [7:0]    tbl_ofs, tbl_data;
  logic          lmmi_request, lmmi_wr_rdn;
  logic [7:0]    lmmi_offset, lmmi_wdata;
  logic          lmmi_ready = 1'b0;
  logic [7:0]    lmmi_rdata = 8'h00;
  logic          lmmi_rdata_valid = 1'b0;
  logic          busy, done, error;
  logic [IW-1:0] err_idx;

  lmmi_cfg_seq #(.NUM_ENTRIES(NE), .OFS_W(8), .DATA_W(8), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .tbl_idx(tbl_idx), .tbl_ofs(tbl_ofs),
    .tbl_data(tbl_data), .lmmi_request(lmmi_request), .lmmi_wr_rdn(lmmi_wr_rdn),
    .lmmi_offset(lmmi_offset), .lmmi_wdata(lmmi_wdata), .lmmi_ready(lmmi_ready),
    .lmmi_rdata(lmmi_rdata), .lmmi_rdata_valid(lmmi_rdata_valid), .busy(busy),
    .done(done), .error(error), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  entry_t tbl [NE];
  int     wdelay [NE];
  int     bad_idx = -1;
  assign tbl_ofs  = tbl[tbl_idx].ofs;
  assign tbl_data = tbl[tbl_idx].data;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Target model: accepts a write after wdelay[entry] wait cycles, reads immediately,
  // returns read data one cycle after the read is accepted.
  entry_t      wlog [$];
  int          nrd = 0, hold = 0, req_run = 0, last_req_run = 0, unstable = 0;
  bit          rd_pending = 0;
  logic [16:0] saved;

  always @(negedge clk) begin
    entry_t e;
    lmmi_rdata_valid = 1'b0;
    if (rd_pending) begin
      lmmi_rdata_valid = 1'b1;
      rd_pending = 0;
    end
    if (lmmi_ready) begin
      lmmi_ready = 1'b0;
      hold = 0;
    end
    if (lmmi_request) begin
      req_run++;
      if (hold == 0) saved = {lmmi_wr_rdn, lmmi_offset, lmmi_wdata};
      else if (saved !== {lmmi_wr_rdn, lmmi_offset, lmmi_wdata}) unstable++;
      if (hold >= (lmmi_wr_rdn ? wdelay[tbl_idx] : 0)) begin
        lmmi_ready = 1'b1;
        if (lmmi_wr_rdn) begin
          e.ofs = lmmi_offset;
          e.data = lmmi_wdata;
          wlog.push_back(e);
        end else begin
          nrd++;
          rd_pending = 1;
          lmmi_rdata = lmmi_wdata ^ ((int'(tbl_idx) == bad_idx) ? 8'h01 : 8'h00);
        end
      end
      hold++;
    end else begin
      hold = 0;
      if (req_run > 0) last_req_run = req_run;
      req_run = 0;
    end
  end

  // Reference: each entry costs its wait cycles plus LOAD/WREQ/NEXT (and the readback pair);
  // the first entry whose wait reaches TMO cycles, or whose readback is corrupted, ends the run.
  task automatic model(output int exp_done, output bit exp_err, output int exp_eidx,
                       output int exp_nwr);
    int t = 0;
    exp_done = -1; exp_err = 0; exp_eidx = 0; exp_nwr = 0;
    for (int i = 0; i < NE; i++) begin
      if (wdelay[i] >= TMO) begin
        exp_err = 1; exp_eidx = i;
        return;
      end
      exp_nwr++;
      t += wdelay[i] + 3 + EXTRA;
      if (EXTRA != 0 && bad_idx == i) begin
        exp_err = 1; exp_eidx = i;
        return;
      end
    end
    exp_done = t;
  endtask

  task automatic do_run(input string tag, input int restart_at);
    int exp_done, exp_eidx, exp_nwr, cyc, done_cyc, busy_n, dones;
    bit exp_err;
    model(exp_done, exp_err, exp_eidx, exp_nwr);
    wlog.delete(); nrd = 0; unstable = 0; last_req_run = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, ".c1_err_clear"}, error, 0);
    chk({tag, ".c1_idx0"}, tbl_idx, 0);
    cyc = 1; done_cyc = -1; busy_n = 0; dones = 0;
    while (cyc <= 400) begin
      if (done) begin dones++; done_cyc = cyc; end
      if (!busy) break;
      busy_n++;
      start = (cyc == restart_at);
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    chk({tag, ".ended"}, cyc <= 400, 1);
    chk({tag, ".done_cyc"}, done_cyc, exp_done);
    chk({tag, ".done_cnt"}, dones, exp_err ? 0 : 1);
    chk({tag, ".error"}, error, exp_err);
    chk({tag, ".err_idx"}, err_idx, exp_err ? exp_eidx : 0);
    if (!exp_err) chk({tag, ".busy_cycles"}, busy_n, exp_done);
    chk({tag, ".n_writes"}, wlog.size(), exp_nwr);
    chk({tag, ".n_reads"}, nrd, (EXTRA != 0) ? exp_nwr : 0);
    for (int i = 0; i < exp_nwr && i < wlog.size(); i++)
      chk($sformatf("%s.wr%0d", tag, i), wlog[i], tbl[i]);
    chk({tag, ".fields_stable"}, unstable, 0);
    if (exp_err && wdelay[exp_eidx] >= TMO)
      chk({tag, ".req_len"}, last_req_run, TMO);
  endtask

  task automatic set_basic();
    tbl[0] = '{ofs: 8'h10, data: 8'hA5};
    tbl[1] = '{ofs: 8'h11, data: 8'h5A};
    tbl[2] = '{ofs: 8'h20, data: 8'hFF};
    tbl[3] = '{ofs: 8'h7F, data: 8'h00};
    for (int i = 0; i < NE; i++) wdelay[i] = 0;
  endtask

  initial begin
    int found;
    set_basic();
    #3;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.error", error, 0);
    chk("rst.err_idx", err_idx, 0);
    chk("rst.request", lmmi_request, 0);
    chk("rst.wr_rdn", lmmi_wr_rdn, 0);
    chk("rst.tbl_idx", tbl_idx, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_run("basic", 0);
    wdelay[2] = 5;
    do_run("slow", 0);
    set_basic();
    do_run("ign_start", 4);
    wdelay[1] = 1000;
    do_run("timeout", 0);
    set_basic();
    do_run("restart", 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NE; i++) begin
        tbl[i].ofs  = 8'($urandom);
        tbl[i].data = 8'($urandom);
        wdelay[i]   = $urandom_range(0, 6);
      end
      if ($urandom_range(0, 3) == 0) wdelay[$urandom_range(0, NE - 1)] = 100;
      do_run($sformatf("rand%0d", r), $urandom_range(0, 8));
    end

    // reset while entry 2's write is waiting for ready
    set_basic();
    wdelay[2] = 30;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      if (tbl_idx == 2 && lmmi_request) found = 1;
      else @(negedge clk);
    end
    chk("midrst.reached", found, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst.request", lmmi_request, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("midrst.busy_after", busy, 0);
    chk("midrst.error_after", error, 0);
    chk("midrst.done_after", done, 0);
    chk("midrst.idx_after", tbl_idx, 0);
    set_basic();
    do_run("post_rst", 0);

`ifdef LMMI_CFG_SEQ_VERIFY_EN
    bad_idx = 0;
    do_run("vfy_mismatch", 0);
    bad_idx = -1;
    do_run("vfy_match", 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lmmi_cfg_seq.md
Name: lmmi_cfg_seq

Overview:
- Configuration sequencer directly upstream of a LIFCL hard-IP primitive's LMMI (Lattice Memory-Mapped Interface) port.
- On a start pulse it walks a table of offset/data pairs and issues one LMMI write per entry, with a timeout on each transaction.
- Used in fuzz and bring-up designs so the hard IP is driven by real register traffic instead of being left unconnected.

Parameters:
- NUM_ENTRIES, 8, number of table entries written per run (1..256)
- OFS_W, 8, LMMI offset width
- DATA_W, 8, LMMI data width
- TMO_CYC, 64, maximum cycles to wait for lmmi_ready (or rdata_valid) before flagging an error (2..1023)

Ports:
- clk  in  1  sequencer and LMMI clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle run request
- tbl_idx  out  $clog2(NUM_ENTRIES) (min 1)  table entry index
- tbl_ofs  in  OFS_W  offset at tbl_idx; combinational table, valid in the same cycle
- tbl_data  in  DATA_W  data at tbl_idx; combinational table, valid in the same cycle
- lmmi_request  out  1  transaction request
- lmmi_wr_rdn  out  1  1 = write, 0 = read
- lmmi_offset  out  OFS_W  register offset
- lmmi_wdata  out  DATA_W  write data
- lmmi_ready  in  1  target accepts the request
- lmmi_rdata  in  DATA_W  read data
- lmmi_rdata_valid  in  1  read data strobe
- busy  out  1  run in progress
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky; cleared by the next accepted start
- err_idx  out  $clog2(NUM_ENTRIES) (min 1)  index of the failing entry

Behaviour:
- Reset values: all outputs 0, state IDLE, index 0, timeout counter 0.
- The LMMI outputs are registered.
- States and transitions:
  - IDLE: start=1 → index 0, error and err_idx cleared → LOAD. start is ignored in every other state.
  - LOAD (1 cycle): register tbl_ofs/tbl_data into lmmi_offset/lmmi_wdata, set lmmi_wr_rdn=1 → WREQ.
  - WREQ: lmmi_request=1 and the request fields held stable until lmmi_ready is sampled high.
    - On ready: drop request next cycle, then go to NEXT.
    - Counter reaches TMO_CYC-1 without ready: → ERR.
  - NEXT: if index == NUM_ENTRIES-1, pulse done and → IDLE; else index+1 → LOAD.
  - ERR (1 cycle): set error=1, err_idx=index, drop request → IDLE.
- Timing: a write accepted with ready in its first request cycle takes 3 cycles per entry (LOAD, WREQ, NEXT). A full run is 3*NUM_ENTRIES cycles from start to done when ready is immediate.
- busy = 1 in every state except IDLE.
- Counter handling: the timeout counter clears on entry to WREQ/RREQ/RWAIT and saturates; it never wraps.
- If lmmi_ready rises in the same cycle the timeout expires, ready wins (success).
- Index arithmetic is unsigned and never exceeds NUM_ENTRIES-1.
- rst asserted mid-run: immediate return to IDLE, lmmi_request drops asynchronously, no done pulse, error cleared.

Optional Feature:
- Macro: LMMI_CFG_SEQ_VERIFY_EN.
- When defined, NEXT is preceded by a readback:
  - RREQ: lmmi_wr_rdn=0, same offset; request held until ready, with timeout.
  - RWAIT: wait for lmmi_rdata_valid, with timeout.
  - Data compare: lmmi_rdata must equal tbl_data; a mismatch → ERR with err_idx = index.
  - Per-entry latency becomes at least 5 cycles.
- Without the macro, no reads are issued: lmmi_rdata and lmmi_rdata_valid are unused and lmmi_wr_rdn stays 1 whenever request is high.

Decomposition:
- Package lmmi_cfg_pkg:
  - state enum (IDLE, LOAD, WREQ, RREQ, RWAIT, NEXT, ERR)
  - LMMI_WRITE/LMMI_READ constants
  - entry struct {ofs, data}
- One sub-module: lmmi_tmo_cnt, a saturating, clearable timeout counter with an expired flag; instanced once.

Test Plan:
- Basic run: NUM_ENTRIES=4, table {(0x10,0xA5),(0x11,0x5A),(0x20,0xFF),(0x7F,0x00)}, ready tied high → four writes in order, done pulse exactly at cycle 12 after start, busy high for cycles 1..12, error=0.
- Slow target: ready delayed 5 cycles on entry 2 → request and fields stable for all 6 cycles; entry 3 follows; done asserted, no error.
- Timeout: ready never asserted on entry 1, TMO_CYC=64 → request drops after 64 cycles, error=1, err_idx=1, no done. A new start clears error and the run restarts at entry 0.
- Reset mid-run: rst asserted during WREQ of entry 2 → lmmi_request=0 within the reset cycle; busy=0, done=0, error=0 after release.
- Ignored start: start pulsed while busy → no restart, index unaffected; done occurs at the original time.
- Verify mismatch (macro on): read of entry 0 returns 0xA4 → error=1, err_idx=0, no write to entry 1. With matching data, done at cycle ≥ 5*NUM_ENTRIES.
